// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// ID->EX issue stage for the ALU. Each cycle it decodes the incoming
// instruction (opcode/funct) into a 3-bit ALU op, chooses operand B (rt or the
// extended immediate), and registers op/A/B into EX. The ID and EX sides both
// use valid/ready handshakes. A one-entry skid buffer lets the ID side keep
// sending while EX stalls, and a flush kills every entry held in the stage.
//
// Optional feature: define ALU_ISSUE_ITYPE_EN to decode the I-type ALU ops
// addi/andi/ori/slti. When it is not defined, those opcodes decode as illegal.
//
// Parameters
//   W      operand width (ALU datapath)
//   IMM_W  immediate field width, extended to W
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   id_valid / id_ready  ID-side handshake (id_ready is registered)
//   opcode, funct        instr[31:26], instr[5:0]
//   rs_val, rt_val       register operands A and B
//   imm                  instr[15:0]
//   flush                synchronous kill of held and incoming entries
//   ex_valid / ex_ready  EX-side handshake
//   ex_op, ex_a, ex_b    ALU op and operands
//   ex_branch            beq: EX tests the ALU zero flag
//   ex_illegal           unsupported encoding (op=000, a=b=0)
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int W     = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [W-1:0]     rs_val,
  input  logic [W-1:0]     rt_val,
  input  logic [IMM_W-1:0] imm,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [2:0]       ex_op,
  output logic [W-1:0]     ex_a,
  output logic [W-1:0]     ex_b,
  output logic             ex_branch,
  output logic             ex_illegal
);

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         branch;
    logic         illegal;
  } entry_t;

  function automatic logic [W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [W-1:0] zext_imm(input logic [IMM_W-1:0] v);
    return {{(W-IMM_W){1'b0}}, v};
  endfunction

  // Decode
  logic [2:0]   dec_op;
  logic         dec_use_imm;
  logic         dec_zext;
  logic         dec_branch;
  logic         dec_illegal;
  logic [W-1:0] imm_ext;
  entry_t       dec_entry;

  always_comb begin
    dec_op      = 3'b000;
    dec_use_imm = 1'b0;
    dec_zext    = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24:   dec_op = 3'b000;
          6'h25:   dec_op = 3'b001;
          6'h20:   dec_op = 3'b010;
          6'h22:   dec_op = 3'b110;
          6'h2A:   dec_op = 3'b111;
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h04: begin
        dec_op     = 3'b110;
        dec_branch = 1'b1;
      end
      6'h23, 6'h2B: begin
        dec_op      = 3'b010;
        dec_use_imm = 1'b1;
      end
`ifdef ALU_ISSUE_ITYPE_EN
      6'h08: begin
        dec_op      = 3'b010;
        dec_use_imm = 1'b1;
      end
      6'h0C: begin
        dec_op      = 3'b000;
        dec_use_imm = 1'b1;
        dec_zext    = 1'b1;
      end
      6'h0D: begin
        dec_op      = 3'b001;
        dec_use_imm = 1'b1;
        dec_zext    = 1'b1;
      end
      6'h0A: begin
        dec_op      = 3'b111;
        dec_use_imm = 1'b1;
      end
`endif
      default: dec_illegal = 1'b1;
    endcase

    imm_ext = dec_zext ? zext_imm(imm) : sext_imm(imm);

    // Illegal entries still flow to EX so the trap logic there sees them,
    // but with a neutral op and zeroed operands.
    dec_entry.op      = dec_illegal ? 3'b000 : dec_op;
    dec_entry.a       = dec_illegal ? '0 : rs_val;
    dec_entry.b       = dec_illegal ? '0 : (dec_use_imm ? imm_ext : rt_val);
    dec_entry.branch  = dec_branch;
    dec_entry.illegal = dec_illegal;
  end

  // Output register (OUT) + skid register (SKID)
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   id_ready_q, id_ready_d;
  logic   accept;

  // id_ready_q is only high while SKID is empty, so an accepted entry always
  // has somewhere to go: OUT when it is free, SKID otherwise.
  assign accept = id_valid & id_ready_q & ~flush;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || ex_ready) begin
      // OUT is empty or drains this cycle. SKID, when full, is older than
      // any new entry. Accept cannot happen while SKID is full.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
    id_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      id_ready_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      id_ready_q   <= id_ready_d;
    end
  end

  assign id_ready   = id_ready_q;
  assign ex_valid   = out_valid_q;
  assign ex_op      = out_q.op;
  assign ex_a       = out_q.a;
  assign ex_b       = out_q.b;
  assign ex_branch  = out_q.branch;
  assign ex_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus a randomized run
// checked against a queue-based reference model of the stage.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_branch;
  logic        ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_stage #(.W(32), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
    .imm(imm), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        ill;
  } ent_t;

  // Reference model: the stage is a 2-deep FIFO whose ready is "fewer than
  // two entries held", except during the first cycle after reset.
  ent_t q[$];
  bit   first_after_rst;

  function automatic ent_t ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [15:0] im);
    ent_t e;
    logic [31:0] sx;
    logic [31:0] zx;
    sx = {{16{im[15]}}, im};
    zx = {16'h0000, im};
    e = '{op: 3'b000, a: rs, b: rt, br: 1'b0, ill: 1'b0};
    if (opc == 6'h00) begin
      if      (fn == 6'h24) e.op = 3'b000;
      else if (fn == 6'h25) e.op = 3'b001;
      else if (fn == 6'h20) e.op = 3'b010;
      else if (fn == 6'h22) e.op = 3'b110;
      else if (fn == 6'h2A) e.op = 3'b111;
      else e.ill = 1'b1;
    end else if (opc == 6'h04) begin
      e.op = 3'b110; e.br = 1'b1;
    end else if (opc == 6'h23 || opc == 6'h2B) begin
      e.op = 3'b010; e.b = sx;
`ifdef ALU_ISSUE_ITYPE_EN
    end else if (opc == 6'h08) begin
      e.op = 3'b010; e.b = sx;
    end else if (opc == 6'h0C) begin
      e.op = 3'b000; e.b = zx;
    end else if (opc == 6'h0D) begin
      e.op = 3'b001; e.b = zx;
    end else if (opc == 6'h0A) begin
      e.op = 3'b111; e.b = sx;
`endif
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) e = '{op: 3'b000, a: 32'h0, b: 32'h0, br: 1'b0, ill: 1'b1};
    return e;
  endfunction

  // Drive one cycle of inputs (called just after a negedge), advance the
  // model across the coming posedge, and return at the next negedge.
  task automatic cycle(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] im, input logic fl, input logic exr);
    bit mrdy;
    id_valid = v; opcode = opc; funct = fn; rs_val = rs; rt_val = rt;
    imm = im; flush = fl; ex_ready = exr;
    mrdy = !first_after_rst && (q.size() < 2);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && exr) void'(q.pop_front());
      if (v && mrdy) q.push_back(ref_decode(opc, fn, rs, rt, im));
    end
    first_after_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input logic exr);
    cycle(1'b0, 6'h3F, 6'h3F, 32'h0, 32'h0, 16'h0, 1'b0, exr);
  endtask

  task automatic test_reset;
    id_valid = 0; opcode = 0; funct = 0; rs_val = 0; rt_val = 0; imm = 0;
    flush = 0; ex_ready = 0;
    rst_n = 1'b0;
    q.delete(); first_after_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ex_valid, ex_op, ex_a, ex_b, ex_branch, ex_illegal} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b op=%b a=%h b=%h br=%b ill=%b, want all zero",
               ex_valid, ex_op, ex_a, ex_b, ex_branch, ex_illegal);
    end
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_id_ready: got %b want 0", id_ready);
    end
    rst_n = 1'b1;
    idle(1'b1);
    n_checks++;
    if (id_ready !== 1'b1 || ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got id_ready=%b ex_valid=%b want 1/0", id_ready, ex_valid);
    end
  endtask

  task automatic test_add;
    cycle(1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if ({ex_valid, ex_op, ex_a, ex_b, ex_branch, ex_illegal} !==
        {1'b1, 3'b010, 32'd5, 32'd7, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add: got v=%b op=%b a=%h b=%h br=%b ill=%b want 1 010 5 7 0 0",
               ex_valid, ex_op, ex_a, ex_b, ex_branch, ex_illegal);
    end
    idle(1'b1);
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_drain: ex_valid got %b want 0", ex_valid);
    end
  endtask

  task automatic test_beq_lw;
    cycle(1'b1, 6'h04, 6'h00, 32'd9, 32'd9, 16'h0010, 1'b0, 1'b1);
    n_checks++;
    if ({ex_valid, ex_op, ex_b, ex_branch, ex_illegal} !== {1'b1, 3'b110, 32'd9, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL beq: got v=%b op=%b b=%h br=%b ill=%b want 1 110 9 1 0",
               ex_valid, ex_op, ex_b, ex_branch, ex_illegal);
    end
    cycle(1'b1, 6'h23, 6'h00, 32'h100, 32'h55, 16'hFFFC, 1'b0, 1'b1);
    n_checks++;
    if ({ex_valid, ex_op, ex_a, ex_b, ex_branch} !== {1'b1, 3'b010, 32'h100, 32'hFFFF_FFFC, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_sext: got v=%b op=%b a=%h b=%h br=%b want 1 010 100 fffffffc 0",
               ex_valid, ex_op, ex_a, ex_b, ex_branch);
    end
    cycle(1'b1, 6'h2B, 6'h00, 32'h200, 32'h55, 16'h7FF0, 1'b0, 1'b1);
    n_checks++;
    if ({ex_op, ex_b} !== {3'b010, 32'h0000_7FF0}) begin
      n_fail++;
      $display("FAIL sw_pos_imm: got op=%b b=%h want 010 00007ff0", ex_op, ex_b);
    end
    idle(1'b1);
  endtask

  task automatic test_illegal_config;
    cycle(1'b1, 6'h08, 6'h00, 32'd11, 32'd99, 16'd3, 1'b0, 1'b1);
    n_checks++;
`ifdef ALU_ISSUE_ITYPE_EN
    if ({ex_valid, ex_op, ex_a, ex_b, ex_illegal} !== {1'b1, 3'b010, 32'd11, 32'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL addi: got v=%b op=%b a=%h b=%h ill=%b want 1 010 b 3 0",
               ex_valid, ex_op, ex_a, ex_b, ex_illegal);
    end
`else
    if ({ex_valid, ex_op, ex_a, ex_b, ex_illegal} !== {1'b1, 3'b000, 32'd0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL addi_illegal: got v=%b op=%b a=%h b=%h ill=%b want 1 000 0 0 1",
               ex_valid, ex_op, ex_a, ex_b, ex_illegal);
    end
`endif
    cycle(1'b1, 6'h00, 6'h3F, 32'd11, 32'd12, 16'd0, 1'b0, 1'b1);
    n_checks++;
    if ({ex_valid, ex_op, ex_a, ex_b, ex_illegal} !== {1'b1, 3'b000, 32'd0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rtype_illegal: got v=%b op=%b a=%h b=%h ill=%b want 1 000 0 0 1",
               ex_valid, ex_op, ex_a, ex_b, ex_illegal);
    end
    idle(1'b1);
  endtask

  task automatic test_backpressure;
    cycle(1'b1, 6'h00, 6'h20, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 6'h00, 6'h22, 32'h3, 32'h4, 16'h0, 1'b0, 1'b0);
    n_checks++;
    if ({id_ready, ex_valid, ex_op, ex_a} !== {1'b0, 1'b1, 3'b010, 32'h1}) begin
      n_fail++;
      $display("FAIL bp_full: got rdy=%b v=%b op=%b a=%h want 0 1 010 1",
               id_ready, ex_valid, ex_op, ex_a);
    end
    // I2 offered while full must be refused.
    cycle(1'b1, 6'h00, 6'h25, 32'h5, 32'h6, 16'h0, 1'b0, 1'b0);
    n_checks++;
    if ({ex_op, ex_a, ex_b} !== {3'b010, 32'h1, 32'h2}) begin
      n_fail++;
      $display("FAIL bp_hold: got op=%b a=%h b=%h want 010 1 2", ex_op, ex_a, ex_b);
    end
    idle(1'b1);
    n_checks++;
    if ({id_ready, ex_valid, ex_op, ex_a, ex_b} !== {1'b1, 1'b1, 3'b110, 32'h3, 32'h4}) begin
      n_fail++;
      $display("FAIL bp_second: got rdy=%b v=%b op=%b a=%h b=%h want 1 1 110 3 4",
               id_ready, ex_valid, ex_op, ex_a, ex_b);
    end
    idle(1'b1);
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: ex_valid got %b want 0", ex_valid);
    end
  endtask

  task automatic test_flush;
    cycle(1'b1, 6'h00, 6'h20, 32'hA, 32'hB, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 6'h00, 6'h24, 32'hC, 32'hD, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 6'h00, 6'h25, 32'hE, 32'hF, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if ({ex_valid, id_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush: got ex_valid=%b id_ready=%b want 0 1", ex_valid, id_ready);
    end
    repeat (3) begin
      idle(1'b1);
      n_checks++;
      if (ex_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_ghost: ex_valid got %b a=%h want 0", ex_valid, ex_a);
      end
    end
  endtask

  task automatic test_random;
    logic [5:0] opcs [10];
    logic [5:0] fns [6];
    logic [5:0] opc, fn;
    logic [31:0] rsv, rtv;
    logic [15:0] im;
    logic v, fl, exr;
    ent_t exp_e;
    opcs = '{6'h00, 6'h00, 6'h00, 6'h04, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0A};
    fns  = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h3F};
    for (int i = 0; i < 400; i++) begin
      opc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 9)];
      fn  = fns[$urandom_range(0, 5)];
      rsv = $urandom; rtv = $urandom; im = 16'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      exr = ($urandom_range(0, 2) != 0);
      cycle(v, opc, fn, rsv, rtv, im, fl, exr);
      n_checks++;
      if (ex_valid !== (q.size() > 0) || id_ready !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got ex_valid=%b id_ready=%b want %b %b",
                 i, ex_valid, id_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        exp_e = q[0];
        n_checks++;
        if ({ex_op, ex_a, ex_b, ex_branch, ex_illegal} !== exp_e) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got op=%b a=%h b=%h br=%b ill=%b want op=%b a=%h b=%h br=%b ill=%b",
                   i, ex_op, ex_a, ex_b, ex_branch, ex_illegal,
                   exp_e.op, exp_e.a, exp_e.b, exp_e.br, exp_e.ill);
        end
      end
    end
    repeat (3) idle(1'b1);
  endtask

  task automatic test_reset_mid_op;
    cycle(1'b1, 6'h00, 6'h20, 32'h11, 32'h22, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 6'h00, 6'h22, 32'h33, 32'h44, 16'h0, 1'b0, 1'b0);
    n_checks++;
    if ({ex_valid, id_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_setup: got ex_valid=%b id_ready=%b want 1 0", ex_valid, id_ready);
    end
    id_valid = 1'b0;
    #1 rst_n = 1'b0;
    q.delete(); first_after_rst = 1'b1;
    #1;
    n_checks++;
    if ({ex_valid, ex_op, ex_a, ex_b, ex_branch, ex_illegal, id_ready} !== 71'h0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b op=%b a=%h b=%h br=%b ill=%b rdy=%b want all zero",
               ex_valid, ex_op, ex_a, ex_b, ex_branch, ex_illegal, id_ready);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle(1'b1);
    n_checks++;
    if ({id_ready, ex_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_release: got id_ready=%b ex_valid=%b want 1 0", id_ready, ex_valid);
    end
    repeat (2) begin
      idle(1'b1);
      n_checks++;
      if (ex_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_ghost: ex_valid got %b a=%h want 0", ex_valid, ex_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq_lw();
    test_illegal_config();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
